// File: rtl/hazard_pkg.sv
// Shared definitions for the load-use hazard unit: FSM state encoding and
// the opcode constants the comparators match against.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } hz_state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Opcode that marks an execute-stage instruction as a load.
    localparam logic [6:0] LOAD_OPC = OPC_LOAD;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts up on inc and holds at all-ones.
module sat_counter
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_reg;

    // Increment on each event until the maximum value is reached.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (inc && (count_reg != CNT_MAX)) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/hazard_unit_param.sv
// Load-use hazard detection with a configurable stall length, plus
// taken-branch flush control and a saturating count of detected hazards.
module hazard_unit_param
    import hazard_pkg::*;
#(
    parameter int                    OPCODE_W = 7,
    parameter int                    REG_AW   = 5,
    parameter int                    LOAD_LAT = 1,
    parameter logic [OPCODE_W-1:0]   LOAD_OPC = OPCODE_W'(hazard_pkg::LOAD_OPC),
    parameter int                    CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic                id_rs1_used,
    input  logic                id_rs2_used,
    input  logic [REG_AW-1:0]   id_rs1,
    input  logic [REG_AW-1:0]   id_rs2,
    input  logic                ex_valid,
    input  logic [OPCODE_W-1:0] ex_opcode,
    input  logic [REG_AW-1:0]   ex_rd,
    input  logic                branch_taken,
    output logic                stall,
    output logic                bubble_ex,
    output logic                flush_if_id,
    output logic                busy,
    output logic [CNT_W-1:0]    stall_events
);

    localparam int                   CNT_BITS = $clog2(LOAD_LAT + 1);
    localparam logic [CNT_BITS-1:0]  CNT_LOAD = CNT_BITS'(LOAD_LAT - 1);
    localparam logic [CNT_BITS-1:0]  CNT_ONE  = CNT_BITS'(1);

    hz_state_e             state_reg, state_next;
    logic [CNT_BITS-1:0]   cnt_reg, cnt_next;

    logic [1:0]            src_used;
    logic [REG_AW-1:0]     src_addr [2];
    logic [1:0]            src_match;
    logic                  ex_is_load;
    logic                  hazard_raw;
    logic                  hazard_accept;

    assign src_used    = {id_rs2_used, id_rs1_used};
    assign src_addr[0] = id_rs1;
    assign src_addr[1] = id_rs2;

    // One comparator per decode source operand against the load destination.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
            assign src_match[gi] = src_used[gi] && (src_addr[gi] == ex_rd);
        end
    endgenerate

    // x0 never produces a real dependency, so a load to it is ignored.
    assign ex_is_load    = ex_valid && (ex_opcode == LOAD_OPC) && (ex_rd != '0);
    assign hazard_raw    = ex_is_load && id_valid && (|src_match);
    assign hazard_accept = rst_n && (state_reg == ST_IDLE) && hazard_raw && !branch_taken;

    // Output decode: branch wins, then IDLE hazard / STALL hold / FLUSH squash.
    always_comb begin
        stall       = 1'b0;
        bubble_ex   = 1'b0;
        flush_if_id = 1'b0;
        if (rst_n) begin
            if (branch_taken) begin
                flush_if_id = 1'b1;
                bubble_ex   = 1'b1;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        stall     = hazard_raw;
                        bubble_ex = hazard_raw;
                    end
                    ST_STALL: begin
                        stall     = 1'b1;
                        bubble_ex = 1'b1;
                    end
                    ST_FLUSH: begin
                        flush_if_id = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy = rst_n && (state_reg != ST_IDLE);

    // Next-state logic; the first stall cycle is spent in IDLE, so STALL
    // covers the remaining LOAD_LAT-1 cycles.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (branch_taken) begin
            state_next = ST_FLUSH;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (hazard_raw && (LOAD_LAT > 1)) begin
                        state_next = ST_STALL;
                        cnt_next   = CNT_LOAD;
                    end
                end
                ST_STALL: begin
                    if (cnt_reg == CNT_ONE) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg - CNT_ONE;
                    end
                end
                ST_FLUSH: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_evt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hazard_accept),
        .count (stall_events)
    );

endmodule

// File: tb/tb_hazard_unit_param.sv
// Bench for hazard_unit_param: a LOAD_LAT=3 instance checked from a vector
// table, and a LOAD_LAT=1 / CNT_W=4 instance checked by hand sequences.
module tb_hazard_unit_param;

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] OP = 7'b0110011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0, id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0;
    logic       ex_valid = 1'b0;
    logic [6:0] ex_opcode = '0;
    logic [4:0] ex_rd = '0;
    logic       branch_taken = 1'b0;

    logic        stall_a, bubble_a, flush_a, busy_a;
    logic [15:0] ev_a;
    logic        stall_b, bubble_b, flush_b, busy_b;
    logic [3:0]  ev_b;

    always #5 clk = ~clk;

    hazard_unit_param #(.LOAD_LAT(3), .CNT_W(16)) u_l3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_valid(ex_valid),
        .ex_opcode(ex_opcode), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .stall(stall_a), .bubble_ex(bubble_a), .flush_if_id(flush_a), .busy(busy_a),
        .stall_events(ev_a)
    );

    hazard_unit_param #(.LOAD_LAT(1), .CNT_W(4)) u_l1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_valid(ex_valid),
        .ex_opcode(ex_opcode), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .stall(stall_b), .bubble_ex(bubble_b), .flush_if_id(flush_b), .busy(busy_b),
        .stall_events(ev_b)
    );

    typedef struct {
        logic        rst_n;
        logic        idv, u1, u2;
        logic [4:0]  rs1, rs2;
        logic        exv;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic        br;
        logic        s, b, f, bz;
        logic [15:0] ev;
    } vec_t;

    typedef struct {
        bit          sel;
        logic        s, b, f, bz;
        logic [15:0] ev;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic r, logic idv, logic u1, logic u2, logic [4:0] rs1,
                                logic [4:0] rs2, logic exv, logic [6:0] opc, logic [4:0] rd,
                                logic br, logic s, logic b, logic f, logic bz, logic [15:0] ev);
        vec_t v;
        v.rst_n = r; v.idv = idv; v.u1 = u1; v.u2 = u2; v.rs1 = rs1; v.rs2 = rs2;
        v.exv = exv; v.opc = opc; v.rd = rd; v.br = br;
        v.s = s; v.b = b; v.f = f; v.bz = bz; v.ev = ev;
        return v;
    endfunction

    // Load to x5 with decode rs1=x5 in use: a hazard.
    function automatic vec_t hz(logic r, logic br, logic s, logic b, logic f, logic bz,
                                logic [15:0] ev);
        return mk(r, 1, 1, 0, 5'd5, 5'd0, 1, LD, 5'd5, br, s, b, f, bz, ev);
    endfunction

    // ALU op in EX, decode reads x1/x2: never a hazard.
    function automatic vec_t nh(logic r, logic br, logic s, logic b, logic f, logic bz,
                                logic [15:0] ev);
        return mk(r, 1, 1, 1, 5'd1, 5'd2, 1, OP, 5'd5, br, s, b, f, bz, ev);
    endfunction

    task automatic apply(input vec_t v, input bit sel, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = v.rst_n; id_valid = v.idv; id_rs1_used = v.u1; id_rs2_used = v.u2;
        id_rs1 = v.rs1; id_rs2 = v.rs2; ex_valid = v.exv; ex_opcode = v.opc;
        ex_rd = v.rd; branch_taken = v.br;
        e.sel = sel; e.s = v.s; e.b = v.b; e.f = v.f; e.bz = v.bz; e.ev = v.ev; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic chk(input string tag, input string fld, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s got=%0h want=%0h", tag, fld, act, exp);
        end
    endtask

    // Pop one expectation per cycle and compare away from the rising edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic s, b, f, bz;
            logic [15:0] ev;
            e = sb.pop_front();
            if (e.sel) begin
                s = stall_b; b = bubble_b; f = flush_b; bz = busy_b; ev = {12'd0, ev_b};
            end else begin
                s = stall_a; b = bubble_a; f = flush_a; bz = busy_a; ev = ev_a;
            end
            chk(e.tag, "stall", {15'd0, s}, {15'd0, e.s});
            chk(e.tag, "bubble_ex", {15'd0, b}, {15'd0, e.b});
            chk(e.tag, "flush_if_id", {15'd0, f}, {15'd0, e.f});
            chk(e.tag, "busy", {15'd0, bz}, {15'd0, e.bz});
            chk(e.tag, "stall_events", ev, e.ev);
            $display("txn %s dut=%0d stall=%0b bub=%0b flush=%0b busy=%0b ev=%0d",
                     e.tag, e.sel, s, b, f, bz, ev);
        end
    end

    vec_t tbl[22];

    initial begin
        int wait_cyc;
        // LOAD_LAT=3 instance: columns are stall, bubble, flush, busy, events.
        tbl[0]  = hz(0, 0, 0, 0, 0, 0, 0);                                   // reset masks hazard
        tbl[1]  = hz(0, 1, 0, 0, 0, 0, 0);                                   // reset masks branch
        tbl[2]  = nh(1, 0, 0, 0, 0, 0, 0);
        tbl[3]  = hz(1, 0, 1, 1, 0, 0, 0);                                   // stall cycle 1
        tbl[4]  = hz(1, 0, 1, 1, 0, 1, 1);                                   // stall cycle 2
        tbl[5]  = hz(1, 0, 1, 1, 0, 1, 1);                                   // stall cycle 3
        tbl[6]  = nh(1, 0, 0, 0, 0, 0, 1);
        tbl[7]  = mk(1, 1, 1, 0, 5'd0, 5'd0, 1, LD, 5'd0, 0, 0, 0, 0, 0, 1); // rd=x0
        tbl[8]  = mk(1, 1, 1, 0, 5'd1, 5'd5, 1, LD, 5'd5, 0, 0, 0, 0, 0, 1); // rs2 unused
        tbl[9]  = mk(1, 1, 1, 1, 5'd1, 5'd5, 1, LD, 5'd5, 0, 1, 1, 0, 0, 1); // rs2 used
        tbl[10] = hz(1, 1, 0, 1, 1, 1, 2);                                   // branch in 2nd stall
        tbl[11] = hz(1, 0, 0, 0, 1, 1, 2);                                   // FLUSH ignores hazard
        tbl[12] = nh(1, 0, 0, 0, 0, 0, 2);
        tbl[13] = mk(1, 1, 1, 0, 5'd5, 5'd0, 0, LD, 5'd5, 0, 0, 0, 0, 0, 2); // ex invalid
        tbl[14] = mk(1, 0, 1, 0, 5'd5, 5'd0, 1, LD, 5'd5, 0, 0, 0, 0, 0, 2); // id invalid
        tbl[15] = mk(1, 1, 1, 0, 5'd5, 5'd0, 1, OP, 5'd5, 0, 0, 0, 0, 0, 2); // not a load
        tbl[16] = hz(1, 1, 0, 1, 1, 0, 2);                                   // branch beats hazard
        tbl[17] = nh(1, 0, 0, 0, 1, 1, 2);
        tbl[18] = hz(1, 0, 1, 1, 0, 0, 2);
        tbl[19] = hz(0, 0, 0, 0, 0, 0, 3);                                   // reset mid-STALL
        tbl[20] = nh(1, 0, 0, 0, 0, 0, 0);
        tbl[21] = nh(1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 22; i++) begin
            apply(tbl[i], 1'b0, $sformatf("l3_v%0d", i));
        end

        // LOAD_LAT=1: single-cycle stall and one event.
        apply(hz(0, 0, 0, 0, 0, 0, 0), 1'b1, "l1_rst");
        apply(hz(1, 0, 1, 1, 0, 0, 0), 1'b1, "l1_haz");
        apply(nh(1, 0, 0, 0, 0, 0, 1), 1'b1, "l1_after");
        apply(nh(1, 0, 0, 0, 0, 0, 1), 1'b1, "l1_idle");

        // CNT_W=4: 17 back-to-back hazards saturate the counter at 15.
        apply(hz(0, 0, 0, 0, 0, 0, 1), 1'b1, "sat_rst");
        for (int k = 0; k < 17; k++) begin
            apply(hz(1, 0, 1, 1, 0, 0, 16'((k > 15) ? 15 : k)), 1'b1, $sformatf("sat_h%0d", k));
        end
        apply(nh(1, 0, 0, 0, 0, 0, 15), 1'b1, "sat_hold0");
        apply(nh(1, 0, 0, 0, 0, 0, 15), 1'b1, "sat_hold1");

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_unit_param.md
HAZARD_UNIT_PARAM -- requirements
Module: hazard_unit_param

Interface
REQ-001 Parameter OPCODE_W, default 7: opcode width of the pipeline-stage opcode buses.
REQ-002 Parameter REG_AW, default 5: register address width.
REQ-003 Parameter LOAD_LAT, default 1, legal 1..4: number of load-use stall cycles inserted per hazard.
REQ-004 Parameter LOAD_OPC, default 7'b0000011: opcode value identifying a load.
REQ-005 Parameter CNT_W, default 16: width of the stall-event counter.
REQ-006 Port clk, input, 1: single clock; all state is updated on the rising edge.
REQ-007 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-008 Ports id_valid, id_rs1_used and id_rs2_used, input, 1 each: decode-stage valid and source-operand use flags.
REQ-009 Ports id_rs1 and id_rs2, input, REG_AW each: decode-stage source register addresses.
REQ-010 Ports ex_valid (input, 1), ex_opcode (input, OPCODE_W) and ex_rd (input, REG_AW): execute-stage instruction.
REQ-011 Port branch_taken, input, 1: resolved taken branch in execute.
REQ-012 Port stall, output, 1: freeze PC and the IF/ID register.
REQ-013 Port bubble_ex, output, 1: insert a NOP into ID/EX.
REQ-014 Port flush_if_id, output, 1: squash the IF/ID register.
REQ-015 Port busy, output, 1: FSM is outside IDLE.
REQ-016 Port stall_events, output, CNT_W: count of hazards detected.

Function
REQ-017 A hazard is detected only when all hold: ex_valid, ex_opcode==LOAD_OPC, ex_rd!=0, id_valid, and ((id_rs1_used && id_rs1==ex_rd) || (id_rs2_used && id_rs2==ex_rd)).
REQ-018 FSM states are IDLE, STALL and FLUSH, with a down-counter cnt of width clog2(LOAD_LAT+1).
REQ-019 In IDLE with a hazard, stall and bubble_ex are asserted combinationally in the same cycle.
REQ-020 On a hazard in IDLE: if LOAD_LAT==1 the FSM stays in IDLE; otherwise it moves to STALL with cnt=LOAD_LAT-1.
REQ-021 In STALL, stall and bubble_ex are asserted unconditionally and cnt decrements each cycle.
REQ-022 STALL returns to IDLE on the cycle cnt==1, so total stall cycles per hazard equal LOAD_LAT exactly.
REQ-023 Hazard inputs seen while in STALL are ignored and neither extend the stall nor count as new events.
REQ-024 branch_taken has priority over everything in any state: flush_if_id=1, bubble_ex=1 and stall=0 that cycle.
REQ-025 A taken branch sets next state to FLUSH and clears cnt, aborting any stall in progress.
REQ-026 FLUSH lasts exactly one cycle with flush_if_id=1 and stall=0, then returns to IDLE.
REQ-027 A hazard during FLUSH is not detected, because the decode instruction has been squashed.
REQ-028 busy = (state != IDLE).
REQ-029 stall_events increments by 1 on each cycle a hazard is accepted in IDLE without branch_taken.
REQ-030 stall_events saturates at 2^CNT_W-1 and does not wrap.

Reset
REQ-031 When rst_n is sampled low on a clk edge: state=IDLE, cnt=0, stall_events=0.
REQ-032 While rst_n is low, outputs are stall=0, bubble_ex=0, flush_if_id=0 and busy=0, regardless of other inputs.
REQ-033 Reset asserted mid-STALL aborts the stall on the next edge, and no partial stall resumes after reset.

Structure
REQ-034 LOAD_OPC, the state encoding typedef and the opcode constants shall live in the shared package hazard_pkg.
REQ-035 The stall-event saturating counter shall be the sub-module sat_counter, parametrised by CNT_W.
REQ-036 The top module shall contain only the comparators, the FSM and the output decode.

Verification
REQ-037 LOAD_LAT=1: EX load with rd=5 and ID rs1=5 used -> stall=1 for exactly 1 cycle, stall_events=1.
REQ-038 LOAD_LAT=3: same stimulus -> stall=1 for 3 consecutive cycles and busy=1 for cycles 2-3.
REQ-039 ex_rd=0 with rs1=0, or rs2 matching with id_rs2_used=0 -> stall=0 throughout.
REQ-040 LOAD_LAT=3, branch_taken in the 2nd stall cycle -> that cycle stall=0 and flush_if_id=1; the next cycle is FLUSH, then IDLE.
REQ-041 rst_n=0 in the middle of STALL -> all outputs 0 on the next edge and stall_events=0.
REQ-042 CNT_W=4 with 17 hazards -> stall_events holds at 15.
